// File: rtl/carry_select_adder_pkg.sv
// rtl/carry_select_adder_pkg.sv - shared mode encoding and default geometry for the carry-select adder pipe
package carry_select_adder_pkg;

  // Operation select carried alongside each operand set.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_STAGES = 4;
  localparam int DEF_BLOCK  = 8;

endpackage

// File: rtl/csa_slice.sv
// rtl/csa_slice.sv - combinational SLICE-bit carry-select adder built from BLOCK-bit blocks
// Ports:
//   i_cin     carry into bit 0 of the slice
//   i_a, i_b  slice operands (i_b already inverted by the caller for subtraction)
//   o_sum     slice sum
//   o_cout    carry out of the slice MSB
//   o_msb_cin carry into the slice MSB (for signed overflow at the top slice)
module csa_slice
  import carry_select_adder_pkg::*;
#(
  parameter int SLICE = DEF_WIDTH / DEF_STAGES,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             i_cin,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_cin
);

  localparam int NBLK = SLICE / BLOCK;

  logic [NBLK:0] w_blk_c;

  assign w_blk_c[0] = i_cin;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic [BLOCK:0] w_s0;
    logic [BLOCK:0] w_s1;

    // Both candidate sums are formed without waiting for the block carry;
    // the incoming carry only steers the mux.
    assign w_s0 = {1'b0, i_a[j*BLOCK +: BLOCK]} + {1'b0, i_b[j*BLOCK +: BLOCK]};
    assign w_s1 = {1'b0, i_a[j*BLOCK +: BLOCK]} + {1'b0, i_b[j*BLOCK +: BLOCK]} + (BLOCK+1)'(1);

    assign o_sum[j*BLOCK +: BLOCK] = w_blk_c[j] ? w_s1[BLOCK-1:0] : w_s0[BLOCK-1:0];
    assign w_blk_c[j+1]            = w_blk_c[j] ? w_s1[BLOCK]     : w_s0[BLOCK];
  end

  assign o_cout = w_blk_c[NBLK];

  // sum = a ^ b ^ carry_in at any bit, so the MSB carry-in falls out of the sum.
  assign o_msb_cin = o_sum[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];

endmodule

// File: rtl/carry_select_adder_pipe.sv
// rtl/carry_select_adder_pipe.sv - STAGES-deep pipelined carry-select adder/subtractor with valid/ready flow control
// Ports:
//   iClk, iRstN          clock (rising edge), asynchronous active-low reset
//   iValid, oReady       operand handshake
//   iA, iB, iCarryIn     operands and carry/borrow in
//   iSub                 0 = add, 1 = subtract
//   oValid, iReady       result handshake
//   oSum, oCarry         result and carry out (NOT borrow for subtract)
//   oOverflow            two's-complement signed overflow
module carry_select_adder_pipe
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int BLOCK  = DEF_BLOCK
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCarryIn,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oSum,
  output logic             oCarry,
  output logic             oOverflow
);

  localparam int SLICE = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || BLOCK < 1 ||
      (WIDTH % STAGES) != 0 || (SLICE % BLOCK) != 0) begin : g_param_check
    $error("carry_select_adder_pipe: illegal WIDTH/STAGES/BLOCK combination");
  end

  // Stage k register: operands (skewed forward), sum bits [0 .. (k+1)*SLICE-1],
  // and the carry out of slice k.
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_c;
  logic              r_ovf;

  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_a_src   [STAGES];
  logic [WIDTH-1:0]  w_b_src   [STAGES];
  logic [WIDTH-1:0]  w_sum_src [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_slice_c;
  logic [SLICE-1:0]  w_slice_sum [STAGES];
  logic              w_msb_cin   [STAGES];
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;

  // Subtraction is a + ~b + ~borrow_in, so mode is folded in before stage 0.
  assign w_b_eff   = (iSub == MODE_SUB) ? ~iB : iB;
  assign w_cin_eff = (iSub == MODE_SUB) ? ~iCarryIn : iCarryIn;

  // A stage may take new contents when empty or when its current contents
  // move on this cycle; evaluated back-to-front from the output handshake.
  always_comb begin
    w_ready = '0;
    w_load  = '0;
    w_ready[STAGES-1] = !r_valid[STAGES-1] || iReady;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_ready[k] = !r_valid[k] || w_ready[k+1];
    end
    w_load[0] = iValid && w_ready[0];
    for (int k = 1; k < STAGES; k++) begin
      w_load[k] = r_valid[k-1] && w_ready[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_src[k]   = iA;
      assign w_b_src[k]   = w_b_eff;
      assign w_c_src[k]   = w_cin_eff;
      assign w_sum_src[k] = '0;
    end else begin : g_next
      assign w_a_src[k]   = r_a[k-1];
      assign w_b_src[k]   = r_b[k-1];
      assign w_c_src[k]   = r_c[k-1];
      assign w_sum_src[k] = r_sum[k-1];
    end

    csa_slice #(
      .SLICE (SLICE),
      .BLOCK (BLOCK)
    ) u_slice (
      .i_cin     (w_c_src[k]),
      .i_a       (w_a_src[k][k*SLICE +: SLICE]),
      .i_b       (w_b_src[k][k*SLICE +: SLICE]),
      .o_sum     (w_slice_sum[k]),
      .o_cout    (w_slice_c[k]),
      .o_msb_cin (w_msb_cin[k])
    );
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_valid <= '0;
      r_c     <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_load[k];
        end
        if (w_load[k]) begin
          r_a[k]   <= w_a_src[k];
          r_b[k]   <= w_b_src[k];
          r_c[k]   <= w_slice_c[k];
          r_sum[k] <= w_sum_src[k];
          r_sum[k][k*SLICE +: SLICE] <= w_slice_sum[k];
        end
      end
      if (w_load[STAGES-1]) begin
        r_ovf <= w_msb_cin[STAGES-1] ^ w_slice_c[STAGES-1];
      end
    end
  end

  assign oValid    = r_valid[STAGES-1];
  assign oReady    = w_ready[0];
  assign oSum      = r_sum[STAGES-1];
  assign oCarry    = r_c[STAGES-1];
  assign oOverflow = r_ovf;

endmodule
